input_buffer: RTL and testbench

Single-clock capture-and-replay buffer for the ADC front end. It captures a batch of `BATCH_SIZE` consecutive samples from `sink_data`, one per clock, into on-chip RAM. It then streams that batch out `RUNS` times as Avalon-ST-style packets (`source_sop`/`source_eop`/`source_valid`) towards the downstream processing chain. Input samples arriving during playback are discarded; capture and playback alternate forever.

---
 rtl/input_buffer.sv | 183 ++++++++++++++++++
 tb/tb_input_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/input_buffer.sv
// ---------------------------------------------------------------------------
// input_buffer
//
// Capture-and-replay buffer for the ADC front end. A batch of BATCH_SIZE
// consecutive samples is written into on-chip RAM, one per clock. The batch
// is then streamed out RUNS times, back to back, as sop/eop framed packets.
// Capture and playback alternate forever. Samples that arrive during playback
// are dropped.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-low reset; release is synchronised
//                     to clk by a two-flop synchroniser
//   sink_data    in   input sample, taken on every edge while filling
//   source_data  out  replayed sample (registered, holds while not valid)
//   source_valid out  source_data carries a replayed sample this cycle
//   source_sop   out  first sample of a packet (only with source_valid)
//   source_eop   out  last sample of a packet (only with source_valid)
//
// Edge 0 is the first rising edge at which the synchronised reset is
// released, i.e. the third rising edge after reset deasserts.
// ---------------------------------------------------------------------------
module input_buffer #(
  parameter int DATA_WIDTH = 14,
  parameter int BATCH_SIZE = 2048,
  parameter int RUNS       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sink_data,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic                  source_valid,
  output logic                  source_sop,
  output logic                  source_eop
);

  localparam int AW = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
  localparam int RW = (RUNS > 1) ? $clog2(RUNS) : 1;

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(BATCH_SIZE - 1);
  localparam logic [RW-1:0] RUN_ZERO  = {RW{1'b0}};
  localparam logic [RW-1:0] RUN_ONE   = RW'(1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(RUNS - 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  logic [1:0]            sync_q;
  logic                  rst_n_s;

  state_e                state_q, state_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [AW-1:0]         raddr_q, raddr_d;
  logic [RW-1:0]         run_q, run_d;
  logic                  wr_en_s;
  logic                  rd_en_s;

  logic [DATA_WIDTH-1:0] mem_q [BATCH_SIZE];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q, rd_sop_q, rd_eop_q;

  logic [DATA_WIDTH-1:0] source_data_q;
  logic                  source_valid_q, source_sop_q, source_eop_q;

  // Reset synchroniser: assertion is immediate, release lands on a clk edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = sync_q[1];

  // Control state register: mode, write/read addresses and run counter.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= ST_FILL;
      waddr_q <= ADDR_ZERO;
      raddr_q <= ADDR_ZERO;
      run_q   <= RUN_ZERO;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic for the FILL/PLAY alternation and address counters.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    run_d   = run_q;
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    case (state_q)
      ST_FILL: begin
        // Held off while in reset so the RAM is left untouched.
        wr_en_s = rst_n_s;
        if (waddr_q == ADDR_LAST) begin
          state_d = ST_PLAY;
          waddr_d = ADDR_ZERO;
          raddr_d = ADDR_ZERO;
          run_d   = RUN_ZERO;
        end else begin
          waddr_d = waddr_q + ADDR_ONE;
        end
      end
      ST_PLAY: begin
        rd_en_s = 1'b1;
        if (raddr_q == ADDR_LAST) begin
          raddr_d = ADDR_ZERO;
          if (run_q == RUN_LAST) begin
            state_d = ST_FILL;
            waddr_d = ADDR_ZERO;
            run_d   = RUN_ZERO;
          end else begin
            run_d = run_q + RUN_ONE;
          end
        end else begin
          raddr_d = raddr_q + ADDR_ONE;
        end
      end
      default: begin
        state_d = ST_FILL;
        waddr_d = ADDR_ZERO;
        raddr_d = ADDR_ZERO;
        run_d   = RUN_ZERO;
      end
    endcase
  end

  // Sample RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[waddr_q] <= sink_data;
    end
  end

  // Sample RAM registered read port.
  always_ff @(posedge clk) begin
    if (rd_en_s) begin
      rd_data_q <= mem_q[raddr_q];
    end
  end

  // Two-stage flag pipeline keeping sop/eop/valid aligned with read data;
  // source_data only advances on valid reads so it holds between packets.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rd_valid_q     <= 1'b0;
      rd_sop_q       <= 1'b0;
      rd_eop_q       <= 1'b0;
      source_valid_q <= 1'b0;
      source_sop_q   <= 1'b0;
      source_eop_q   <= 1'b0;
      source_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_valid_q     <= rd_en_s;
      rd_sop_q       <= rd_en_s && (raddr_q == ADDR_ZERO);
      rd_eop_q       <= rd_en_s && (raddr_q == ADDR_LAST);
      source_valid_q <= rd_valid_q;
      source_sop_q   <= rd_sop_q;
      source_eop_q   <= rd_eop_q;
      if (rd_valid_q) begin
        source_data_q <= rd_data_q;
      end
    end
  end

  assign source_data  = source_data_q;
  assign source_valid = source_valid_q;
  assign source_sop   = source_sop_q;
  assign source_eop   = source_eop_q;

endmodule

// File: tb/tb_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_input_buffer
//
// Directed bench for input_buffer. Instance A uses BATCH_SIZE=8, RUNS=3;
// instance B uses BATCH_SIZE=2, RUNS=1. Inputs are driven and outputs are
// sampled on the falling edge. Edge k counts from the first rising edge after
// the two-flop reset synchroniser has released.
// ---------------------------------------------------------------------------
module tb_input_buffer;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset_a, reset_b;
  logic [DW-1:0] sink_a, sink_b;
  logic [DW-1:0] data_a, data_b;
  logic          valid_a, sop_a, eop_a;
  logic          valid_b, sop_b, eop_b;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] pat [8];

  always #5 clk = ~clk;

  input_buffer #(.DATA_WIDTH(DW), .BATCH_SIZE(8), .RUNS(3)) dut_a (
    .clk          (clk),
    .reset        (reset_a),
    .sink_data    (sink_a),
    .source_data  (data_a),
    .source_valid (valid_a),
    .source_sop   (sop_a),
    .source_eop   (eop_a)
  );

  input_buffer #(.DATA_WIDTH(DW), .BATCH_SIZE(2), .RUNS(1)) dut_b (
    .clk          (clk),
    .reset        (reset_b),
    .sink_data    (sink_b),
    .source_data  (data_b),
    .source_valid (valid_b),
    .source_sop   (sop_b),
    .source_eop   (eop_b)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d got=%h want=%h", tag, k, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input int k,
                      input logic v, input logic s, input logic e, input logic [DW-1:0] d,
                      input logic ev, input logic es, input logic ee, input logic [DW-1:0] ed);
    chk({tag, "_valid"}, k, 32'(v), 32'(ev));
    chk({tag, "_sop"},   k, 32'(s), 32'(es));
    chk({tag, "_eop"},   k, 32'(e), 32'(ee));
    chk({tag, "_data"},  k, 32'(d), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic          ev, es, ee;
    logic [DW-1:0] ed, last;
    int            j, m, b;

    pat[0] = 14'h2000; pat[1] = 14'h1FFF; pat[2] = 14'h3FFF; pat[3] = 14'h0000;
    pat[4] = 14'h2AAA; pat[5] = 14'h1555; pat[6] = 14'h0001; pat[7] = 14'h3FFE;

    reset_a = 1'b0;
    reset_b = 1'b0;
    sink_a  = 14'd0;
    sink_b  = 14'd0;
    @(negedge clk);

    // Outputs held at zero while reset is asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("rst_a", i, valid_a, sop_a, eop_a, data_a, 1'b0, 1'b0, 1'b0, 14'd0);
      chk4("rst_b", i, valid_b, sop_b, eop_b, data_b, 1'b0, 1'b0, 1'b0, 14'd0);
    end

    // Release A; two synchroniser edges before edge 0.
    reset_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk4("sync_a", i, valid_a, sop_a, eop_a, data_a, 1'b0, 1'b0, 1'b0, 14'd0);
    end

    // Ramp 10+k throughout: first batch 10..17, second batch 42..49.
    last = 14'd0;
    for (int k = 0; k <= 46; k++) begin
      sink_a = 14'(10 + k);
      tick();
      if (k >= 9 && k <= 32) begin
        j = k - 9;
        ev = 1'b1; es = (j % 8 == 0); ee = (j % 8 == 7);
        ed = 14'(10 + j % 8);
        last = ed;
      end else if (k >= 41) begin
        j = k - 41;
        ev = 1'b1; es = (j % 8 == 0); ee = (j % 8 == 7);
        ed = 14'(42 + j % 8);
        last = ed;
      end else begin
        ev = 1'b0; es = 1'b0; ee = 1'b0;
        ed = last;
      end
      chk4("replay", k, valid_a, sop_a, eop_a, data_a, ev, es, ee, ed);
    end

    // Reset mid-packet after offset 5: outputs clear without a clock edge.
    #2;
    reset_a = 1'b0;
    #1;
    chk4("async_rst", 0, valid_a, sop_a, eop_a, data_a, 1'b0, 1'b0, 1'b0, 14'd0);
    @(negedge clk);
    tick();
    tick();
    chk4("held_rst", 0, valid_a, sop_a, eop_a, data_a, 1'b0, 1'b0, 1'b0, 14'd0);
    reset_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk4("sync2_a", i, valid_a, sop_a, eop_a, data_a, 1'b0, 1'b0, 1'b0, 14'd0);
    end

    // Fresh capture of corner values, then full 3-run replay.
    last = 14'd0;
    for (int k = 0; k <= 34; k++) begin
      sink_a = (k < 8) ? pat[k] : 14'(k * 7 + 3);
      tick();
      if (k >= 9 && k <= 32) begin
        j = k - 9;
        ev = 1'b1; es = (j % 8 == 0); ee = (j % 8 == 7);
        ed = pat[j % 8];
        last = ed;
      end else begin
        ev = 1'b0; es = 1'b0; ee = 1'b0;
        ed = last;
      end
      chk4("corner", k, valid_a, sop_a, eop_a, data_a, ev, es, ee, ed);
    end

    // Instance B: 2-sample packets, single run, period 4.
    reset_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk4("sync_b", i, valid_b, sop_b, eop_b, data_b, 1'b0, 1'b0, 1'b0, 14'd0);
    end
    last = 14'd0;
    for (int k = 0; k <= 12; k++) begin
      sink_b = 14'(100 + k);
      tick();
      ev = 1'b0; es = 1'b0; ee = 1'b0; ed = last;
      if (k >= 3) begin
        m = (k - 3) % 4;
        b = (k - 3) / 4;
        if (m < 2) begin
          ev = 1'b1; es = (m == 0); ee = (m == 1);
          ed = 14'(100 + 4 * b + m);
          last = ed;
        end
      end
      chk4("small", k, valid_b, sop_b, eop_b, data_b, ev, es, ee, ed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
